qam_mdemap_fifo: RTL

- Parametrised next-generation hard-decision QAM demapper with a runtime-selectable constellation: QPSK, 16QAM or 64QAM.
- Slices signed I/Q symbols against programmable grid thresholds and Gray-decodes each axis.
- Buffers the bit words in an internal synchronous FIFO with valid/ready handshakes on both sides.
- Single clock domain; sits between the symbol front end and the bit sink.

---
 rtl/qam_pkg.sv | 57 +++++
 rtl/qam_sync_fifo.sv | 65 ++++++
 rtl/qam_mdemap_fifo.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/qam_pkg.sv
// Shared types and helpers for the QAM demapper: mode encodings, per-mode constants,
// the threshold slicer and the Gray decoder.
package qam_pkg;

    typedef enum logic [1:0] {
        MODE_QPSK  = 2'd0,
        MODE_16QAM = 2'd1,
        MODE_64QAM = 2'd2,
        MODE_RSVD  = 2'd3
    } qam_mode_e;

    localparam int LEVELS_QPSK  = 2;
    localparam int LEVELS_16QAM = 4;
    localparam int LEVELS_64QAM = 8;

    localparam logic [2:0] NBITS_QPSK  = 3'd2;
    localparam logic [2:0] NBITS_16QAM = 3'd4;
    localparam logic [2:0] NBITS_64QAM = 3'd6;

    // Slicer arithmetic is carried in a wide signed type so 6*d never wraps for any IQ_W up to 28.
    localparam int SLICE_W = 32;
    typedef logic signed [SLICE_W-1:0] slice_t;

    function automatic int levels_of(input qam_mode_e m);
        case (m)
            MODE_16QAM: return LEVELS_16QAM;
            MODE_64QAM: return LEVELS_64QAM;
            default:    return LEVELS_QPSK;
        endcase
    endfunction

    function automatic logic [2:0] nbits_of(input qam_mode_e m);
        case (m)
            MODE_16QAM: return NBITS_16QAM;
            MODE_64QAM: return NBITS_64QAM;
            default:    return NBITS_QPSK;
        endcase
    endfunction

    function automatic logic [2:0] gray_of(input logic [2:0] idx);
        return idx ^ (idx >> 1);
    endfunction

    // Counts thresholds 2*d*j (|j| <= levels/2-1) that x reaches; ties round up, outer values clamp.
    function automatic logic [2:0] level_count(input slice_t x, input slice_t d, input int levels);
        logic [2:0] cnt;
        int         half;
        cnt  = 3'd0;
        half = levels / 2 - 1;
        for (int j = -3; j <= 3; j++) begin
            if (j >= -half && j <= half && x >= slice_t'(2 * j) * d)
                cnt = cnt + 3'd1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/qam_sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers; the head word is visible while non-empty
// and the last displayed word is held once it drains.
module qam_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] head;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_wr   = wr_en && !full && !clear;
    assign do_rd   = rd_en && !empty && !clear;
    assign head    = mem[rd_ptr[AW-1:0]];
    assign rd_data = empty ? hold_q : head;

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Capture the head whenever it leaves the output so rd_data keeps its last value when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold_q <= '0;
        else if (!empty && (clear || do_rd))
            hold_q <= head;
    end

endmodule

// File: rtl/qam_mdemap_fifo.sv
// Hard-decision QPSK/16QAM/64QAM demapper: slicer stage feeding a show-ahead output FIFO.
// Define QAM_EVM_EN to add err_out, the L1 distance to the decided point, stored with each word.
module qam_mdemap_fifo
    import qam_pkg::*;
#(
    parameter int IQ_W       = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sclk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [1:0]                    mode,
    input  logic [IQ_W-1:0]               unit_d,
    input  logic signed [IQ_W-1:0]        I_in,
    input  logic signed [IQ_W-1:0]        Q_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [5:0]                    data_out,
    output logic [2:0]                    nbits,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
`ifdef QAM_EVM_EN
    output logic [IQ_W+2:0]               err_out,
`endif
    output logic                          mode_err
);

    localparam int BASE_W = 9;
`ifdef QAM_EVM_EN
    localparam int WORD_W = BASE_W + IQ_W + 3;
`else
    localparam int WORD_W = BASE_W;
`endif

    logic                   ready_en;
    logic                   accept;
    logic                   s1_valid;
    qam_mode_e              s1_mode;
    logic signed [IQ_W-1:0] s1_i;
    logic signed [IQ_W-1:0] s1_q;
    logic [IQ_W-1:0]        s1_d;

    int                     levels;
    slice_t                 i_ext;
    slice_t                 q_ext;
    slice_t                 d_ext;
    logic [2:0]             idx_i;
    logic [2:0]             idx_q;
    logic [2:0]             gray_i;
    logic [2:0]             gray_q;
    logic [5:0]             word_bits;
    logic [WORD_W-1:0]      wr_word;
    logic [WORD_W-1:0]      rd_word;
    logic                   fifo_empty;

    // Capacity counts the slicer stage too, so a full FIFO plus one in-flight symbol stalls input.
    assign in_ready = ready_en && ((int'(fifo_level) + int'(s1_valid)) < FIFO_DEPTH);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
            mode_err <= 1'b0;
            s1_valid <= 1'b0;
            s1_mode  <= MODE_QPSK;
            s1_i     <= '0;
            s1_q     <= '0;
            s1_d     <= '0;
        end else begin
            ready_en <= 1'b1;
            s1_valid <= accept && !flush;
            if (accept && mode == MODE_RSVD)
                mode_err <= 1'b1;
            if (accept) begin
                s1_mode <= (mode == MODE_RSVD) ? MODE_QPSK : qam_mode_e'(mode);
                s1_i    <= I_in;
                s1_q    <= Q_in;
                s1_d    <= unit_d;
            end
        end
    end

    always_comb begin
        levels = levels_of(s1_mode);
        i_ext  = slice_t'(s1_i);
        q_ext  = slice_t'(s1_q);
        d_ext  = slice_t'(s1_d);
        idx_i  = level_count(i_ext, d_ext, levels);
        idx_q  = level_count(q_ext, d_ext, levels);
        gray_i = gray_of(idx_i);
        gray_q = gray_of(idx_q);
        case (s1_mode)
            MODE_16QAM: word_bits = {2'b00, gray_i[1:0], gray_q[1:0]};
            MODE_64QAM: word_bits = {gray_i, gray_q};
            default:    word_bits = {4'b0000, gray_i[0], gray_q[0]};
        endcase
    end

`ifdef QAM_EVM_EN
    slice_t           hat_i;
    slice_t           hat_q;
    slice_t           dist_i;
    slice_t           dist_q;
    logic [IQ_W+2:0]  err_word;

    // Ideal points sit at odd multiples of d: (2*idx - (L-1)) * d.
    always_comb begin
        hat_i    = (slice_t'(2 * int'(idx_i)) - slice_t'(levels - 1)) * d_ext;
        hat_q    = (slice_t'(2 * int'(idx_q)) - slice_t'(levels - 1)) * d_ext;
        dist_i   = (i_ext >= hat_i) ? (i_ext - hat_i) : (hat_i - i_ext);
        dist_q   = (q_ext >= hat_q) ? (q_ext - hat_q) : (hat_q - q_ext);
        err_word = (IQ_W+3)'(dist_i + dist_q);
    end

    assign wr_word = {err_word, nbits_of(s1_mode), word_bits};
    assign err_out = rd_word[WORD_W-1:BASE_W];
`else
    assign wr_word = {nbits_of(s1_mode), word_bits};
`endif

    qam_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sclk),
        .rst_n   (rst_n),
        .clear   (flush),
        .wr_en   (s1_valid),
        .wr_data (wr_word),
        .rd_en   (out_ready),
        .rd_data (rd_word),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign out_valid = !fifo_empty;
    assign data_out  = rd_word[5:0];
    assign nbits     = rd_word[8:6];

endmodule
